pio_ram_arbiter: RTL and testbench

- Shares the single 2-pin serial link to the PIO RAM emulator between two requesters: port 0 (video fetch, high priority) and port 1 (CPU/general).
- Accepts one transaction at a time and serializes header, address and write data onto tx_pins.
- For reads, waits for the emulator's start marker on rx_pins, deserializes the data, and returns it to the originating port.
- Sits inside the TT project between the requesters and the uio_out[5:4] / uio_in[7:6] pins.

---
 rtl/pio_ram_arb_pkg.sv | 25 ++
 rtl/pio_ram_serdes.sv | 37 +++
 rtl/pio_ram_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_pio_ram_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_ram_arb_pkg.sv
// Shared state encoding, link symbols and beat-count helpers for the PIO RAM link arbiter.
package pio_ram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_WDATA,
        ST_WAIT,
        ST_RDATA
    } state_t;

    localparam logic [1:0] HDR_READ  = 2'b01;
    localparam logic [1:0] HDR_WRITE = 2'b10;
    localparam logic [1:0] RX_START  = 2'b11;

    function automatic int beat_count(input int bits, input int io_bits);
        return bits / io_bits;
    endfunction

    function automatic int count_width(input int beats);
        return $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/pio_ram_serdes.sv
// MSB-first shift register with a beat counter; done flags the final beat of WIDTH/IO_BITS.
module pio_ram_serdes
    import pio_ram_arb_pkg::*;
#(
    parameter int   WIDTH   = 16,
    parameter int   IO_BITS = 2,
    localparam int  BEATS   = beat_count(WIDTH, IO_BITS),
    localparam int  CNT_W   = count_width(BEATS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_data,
    input  logic               shift,
    input  logic [IO_BITS-1:0] shift_in,
    output logic [WIDTH-1:0]   data,
    output logic [CNT_W-1:0]   count,
    output logic               done
);

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= '0;
            count <= '0;
        end else if (load) begin
            data  <= load_data;
            count <= '0;
        end else if (shift) begin
            data  <= {data[WIDTH-IO_BITS-1:0], shift_in};
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == CNT_W'(BEATS - 1));

endmodule

// File: rtl/pio_ram_arbiter.sv
// Two-port arbiter serializing requests onto the 2-pin PIO RAM link.
// Define PIO_RAM_ARB_TIMEOUT_EN to bound the read wait and add the sticky timeout_err output.
module pio_ram_arbiter
    import pio_ram_arb_pkg::*;
#(
    parameter int ADDR_BITS      = 16,
    parameter int DATA_BITS      = 16,
    parameter int IO_BITS        = 2,
    parameter int MAX_CONSEC_HI  = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_write,
    input  logic [ADDR_BITS-1:0] req_addr0,
    input  logic [ADDR_BITS-1:0] req_addr1,
    input  logic [DATA_BITS-1:0] req_wdata0,
    input  logic [DATA_BITS-1:0] req_wdata1,
    output logic [1:0]           rsp_valid,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic [IO_BITS-1:0]   tx_pins,
    input  logic [IO_BITS-1:0]   rx_pins,
    output logic                 busy
`ifdef PIO_RAM_ARB_TIMEOUT_EN
    ,
    output logic                 timeout_err
`endif
);

    localparam int ADDR_BEATS = beat_count(ADDR_BITS, IO_BITS);
    localparam int DATA_BEATS = beat_count(DATA_BITS, IO_BITS);
    localparam int TX_BITS    = IO_BITS + ADDR_BITS + DATA_BITS;
    localparam int TX_CNT_W   = count_width(beat_count(TX_BITS, IO_BITS));
    localparam int RX_CNT_W   = count_width(DATA_BEATS);
    localparam int HI_W       = $clog2(MAX_CONSEC_HI + 2);

    state_t               state, state_next;
    logic [1:0]           grant;
    logic                 accept;
    logic                 hi_block;
    logic                 sel_write;
    logic [IO_BITS-1:0]   sel_hdr;
    logic [TX_BITS-1:0]   tx_load_data;
    logic                 port_id;
    logic                 is_write;
    logic [HI_W-1:0]      hi_cnt;

    logic                 tx_shift, tx_done;
    logic [TX_BITS-1:0]   tx_data;
    logic [TX_CNT_W-1:0]  tx_count;
    logic                 rx_load, rx_shift, rx_done;
    logic [DATA_BITS-1:0] rx_data, rx_word;
    logic [RX_CNT_W-1:0]  rx_count;

    logic [1:0]           rsp_valid_next;
    logic                 rdata_load;
    logic [DATA_BITS-1:0] rdata_next;

    // Port 0 wins unless port 1 has already watched MAX_CONSEC_HI port-0 grants go by.
    always_comb begin
        hi_block = req_valid[1] && (hi_cnt == HI_W'(MAX_CONSEC_HI));
        grant    = 2'b00;
        if (state == ST_IDLE) begin
            if (req_valid[0] && !hi_block)
                grant = 2'b01;
            else if (req_valid[1])
                grant = 2'b10;
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign sel_write = grant[1] ? req_write[1] : req_write[0];
    assign sel_hdr   = sel_write ? IO_BITS'(HDR_WRITE) : IO_BITS'(HDR_READ);

    // Header, address and data leave as one frame; read data slots are zero so the pins idle low.
    assign tx_load_data = grant[1]
        ? {sel_hdr, req_addr1, sel_write ? req_wdata1 : {DATA_BITS{1'b0}}}
        : {sel_hdr, req_addr0, sel_write ? req_wdata0 : {DATA_BITS{1'b0}}};

    pio_ram_serdes #(.WIDTH(TX_BITS), .IO_BITS(IO_BITS)) u_tx (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_data (tx_load_data),
        .shift     (tx_shift),
        .shift_in  ({IO_BITS{1'b0}}),
        .data      (tx_data),
        .count     (tx_count),
        .done      (tx_done)
    );

    pio_ram_serdes #(.WIDTH(DATA_BITS), .IO_BITS(IO_BITS)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .load      (rx_load),
        .load_data ({DATA_BITS{1'b0}}),
        .shift     (rx_shift),
        .shift_in  (rx_pins),
        .data      (rx_data),
        .count     (rx_count),
        .done      (rx_done)
    );

    assign tx_pins = tx_data[TX_BITS-1 -: IO_BITS];
    assign rx_word = {rx_data[DATA_BITS-IO_BITS-1:0], rx_pins};
    assign busy    = (state != ST_IDLE);

    logic unused_bits;
    assign unused_bits = ^{tx_data[TX_BITS-IO_BITS-1:0], rx_data[DATA_BITS-1 -: IO_BITS], rx_count};

`ifdef PIO_RAM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wait_cnt;
    logic            timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + TO_W'(1) : '0;
            if (timeout_hit)
                timeout_err <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        tx_shift       = 1'b0;
        rx_load        = 1'b0;
        rx_shift       = 1'b0;
        rsp_valid_next = 2'b00;
        rdata_load     = 1'b0;
        rdata_next     = rx_word;
`ifdef PIO_RAM_ARB_TIMEOUT_EN
        timeout_hit    = 1'b0;
`endif
        unique case (state)
            ST_IDLE: begin
                if (accept)
                    state_next = ST_HDR;
            end
            ST_HDR: begin
                tx_shift   = 1'b1;
                state_next = ST_ADDR;
            end
            ST_ADDR: begin
                tx_shift = 1'b1;
                if (tx_count == TX_CNT_W'(ADDR_BEATS))
                    state_next = is_write ? ST_WDATA : ST_WAIT;
            end
            ST_WDATA: begin
                tx_shift = 1'b1;
                if (tx_done)
                    state_next = ST_IDLE;
            end
            ST_WAIT: begin
                if (rx_pins == IO_BITS'(RX_START)) begin
                    rx_load    = 1'b1;
                    state_next = ST_RDATA;
                end
`ifdef PIO_RAM_ARB_TIMEOUT_EN
                else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_hit             = 1'b1;
                    rsp_valid_next[port_id] = 1'b1;
                    rdata_load              = 1'b1;
                    rdata_next              = '1;
                    state_next              = ST_IDLE;
                end
`endif
            end
            ST_RDATA: begin
                rx_shift = 1'b1;
                if (rx_done) begin
                    rsp_valid_next[port_id] = 1'b1;
                    rdata_load              = 1'b1;
                    state_next              = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            port_id   <= 1'b0;
            is_write  <= 1'b0;
            hi_cnt    <= '0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
        end else begin
            state     <= state_next;
            rsp_valid <= rsp_valid_next;
            if (rdata_load)
                rsp_rdata <= rdata_next;
            if (accept) begin
                port_id  <= grant[1];
                is_write <= sel_write;
                hi_cnt   <= (grant[0] && req_valid[1]) ? hi_cnt + HI_W'(1) : '0;
            end
        end
    end

endmodule

// File: tb/tb_pio_ram_arbiter.sv
// Directed self-checking bench for pio_ram_arbiter (16-bit addr/data, 2-bit link).
// Timeout steps run only when PIO_RAM_ARB_TIMEOUT_EN is defined.
module tb_pio_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
    logic [15:0] req_addr0, req_addr1, req_wdata0, req_wdata1, rsp_rdata;
    logic [1:0]  tx_pins, rx_pins;
    logic        busy;
`ifdef PIO_RAM_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    int checks   = 0;
    int failures = 0;
    int n;
    int gap;

    logic [1:0] rd_tx   [9]  = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00};
    logic [1:0] wr_tx   [17] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11,
                                 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11};
    logic [1:0] beef_rx [8]  = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11};
    logic [1:0] d1357_rx[8]  = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11};
    logic [1:0] arb_exp [6]  = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};

    always #5 clk = ~clk;

    pio_ram_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .tx_pins    (tx_pins),
        .rx_pins    (rx_pins),
        .busy       (busy)
`ifdef PIO_RAM_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b00;
        req_write  = 2'b00;
        req_addr0  = '0;
        req_addr1  = '0;
        req_wdata0 = '0;
        req_wdata1 = '0;
        rx_pins    = 2'b00;
        repeat (2) @(posedge clk);
        #2;

        // Reset state
        check("reset_tx", tx_pins, 2'b00);
        check("reset_ready", req_ready, 2'b00);
        check("reset_rsp_valid", rsp_valid, 2'b00);
        check("reset_rdata", rsp_rdata, 16'h0000);
        check("reset_busy", busy, 1'b0);
`ifdef PIO_RAM_ARB_TIMEOUT_EN
        check("reset_timeout_err", timeout_err, 1'b0);
`endif
        reset = 1'b0;
        step();

        // Port-0 read of 0x1234 returning 0xBEEF
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr0 = 16'h1234;
        #1 check("rd_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("rd_busy", busy, 1'b1);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("rd_tx%0d", i), tx_pins, rd_tx[i]);
            step();
        end
        check("rd_wait_tx", tx_pins, 2'b00);
        rx_pins = 2'b01;
        step();
        check("rd_wait_hold_busy", busy, 1'b1);
        check("rd_wait_hold_tx", tx_pins, 2'b00);
        rx_pins = 2'b11;
        step();
        for (int i = 0; i < 8; i++) begin
            rx_pins = beef_rx[i];
            check($sformatf("rd_no_rsp%0d", i), rsp_valid, 2'b00);
            step();
        end
        rx_pins = 2'b00;
        check("rd_rsp_valid", rsp_valid, 2'b01);
        check("rd_rdata", rsp_rdata, 16'hBEEF);
        check("rd_done_busy", busy, 1'b0);
        step();
        check("rd_rsp_pulse_end", rsp_valid, 2'b00);
        check("rd_rdata_hold", rsp_rdata, 16'hBEEF);

        // Port-1 write of 0xA5C3 to 0x0003
        req_valid  = 2'b10;
        req_write  = 2'b10;
        req_addr1  = 16'h0003;
        req_wdata1 = 16'hA5C3;
        #1 check("wr_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        for (int i = 0; i < 17; i++) begin
            check($sformatf("wr_tx%0d", i), tx_pins, wr_tx[i]);
            check($sformatf("wr_busy%0d", i), busy, 1'b1);
            check($sformatf("wr_no_rsp%0d", i), rsp_valid, 2'b00);
            step();
        end
        check("wr_idle_busy", busy, 1'b0);
        check("wr_idle_tx", tx_pins, 2'b00);
        check("wr_idle_rsp", rsp_valid, 2'b00);

        // Both ports requesting writes continuously
        req_valid  = 2'b11;
        req_write  = 2'b11;
        req_addr0  = 16'h0100;
        req_addr1  = 16'h0200;
        req_wdata0 = 16'h1111;
        req_wdata1 = 16'h2222;
        n = 0;
        for (int c = 0; c < 200 && n < 6; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                check($sformatf("arb_grant%0d", n), req_ready, arb_exp[n]);
                n++;
            end
            step();
        end
        check("arb_grant_count", n, 6);
        req_valid = 2'b00;
        for (int c = 0; c < 40 && busy; c++) step();
        check("arb_drain_idle", busy, 1'b0);

        // Port 1 alone, then port 0 arrives mid-transaction
        req_valid = 2'b10;
        req_write = 2'b10;
        #1 check("p1_alone_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b01;
        req_write = 2'b01;
        gap = 1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req_ready != 2'b00) break;
            step();
            gap++;
        end
        check("p0_after_p1_grant", req_ready, 2'b01);
        check("p0_after_p1_gap", gap, 18);
        step();
        req_valid = 2'b00;
        for (int c = 0; c < 40 && busy; c++) step();
        check("p0_drain_idle", busy, 1'b0);

        // Reset during WAIT of a read
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr0 = 16'h00FF;
        #1 check("rst_rd_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        repeat (9) step();
        check("rst_pre_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_tx", tx_pins, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp", rsp_valid, 2'b00);
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rx_pins = (i == 0) ? 2'b11 : beef_rx[i % 8];
            check($sformatf("rst_no_rsp%0d", i), rsp_valid, 2'b00);
            step();
        end
        rx_pins = 2'b00;

        // Next read (port 1) completes normally
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr1 = 16'h00FF;
        #1 check("post_rst_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        repeat (9) step();
        check("post_rst_wait_tx", tx_pins, 2'b00);
        rx_pins = 2'b11;
        step();
        for (int i = 0; i < 8; i++) begin
            rx_pins = d1357_rx[i];
            step();
        end
        rx_pins = 2'b00;
        check("post_rst_rsp_valid", rsp_valid, 2'b10);
        check("post_rst_rdata", rsp_rdata, 16'h1357);
        step();
        check("post_rst_rsp_end", rsp_valid, 2'b00);

`ifdef PIO_RAM_ARB_TIMEOUT_EN
        // Read with no start marker times out after 8 WAIT cycles
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr0 = 16'h0010;
        #1 check("to_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        gap = 1;
        for (int c = 0; c < 60; c++) begin
            if (rsp_valid != 2'b00) break;
            step();
            gap++;
        end
        check("to_rsp_valid", rsp_valid, 2'b01);
        check("to_rdata", rsp_rdata, 16'hFFFF);
        check("to_err", timeout_err, 1'b1);
        check("to_gap", gap, 18);
        req_valid = 2'b10;
        req_write = 2'b10;
        #1 check("to_next_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        for (int c = 0; c < 40 && busy; c++) step();
        check("to_err_sticky", timeout_err, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
